// File: rtl/spi_bs_pkg.sv
// -----------------------------------------------------------------------------
// spi_bs_pkg
// Shared types and constants for the byte-oriented SPI master (spi_bs).
//   state_t    : controller states (IDLE, XFER)
//   BYTE_W     : transfer width in bits (fixed at 8)
//   BIT_CNT_W  : width of the bit-position counter
//   LAST_BIT   : bit-counter value of the final bit of a byte
// Optional build macro affecting users of this package: SPI_BS_LSB_FIRST_EN.
// -----------------------------------------------------------------------------
package spi_bs_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

endpackage

// File: rtl/spi_bs_clkgen.sv
// -----------------------------------------------------------------------------
// spi_bs_clkgen
// SPI clock generator for spi_bs. While enabled, a divider counts
// 0..CLK_DIV-1 system clocks; on terminal count sclk toggles and the counter
// wraps. While disabled, sclk is forced low and the divider is cleared so the
// next enable starts a full half-period before the first rising edge.
//
// Ports:
//   clock    in   system clock (rising edge)
//   reset    in   asynchronous active-high reset
//   i_en     in   run the divider (high while a transfer is in progress)
//   o_sclk   out  registered SPI clock, idles low
//   o_rise   out  one-clock strobe: sclk goes 0->1 on this clock edge
//   o_fall   out  one-clock strobe: sclk goes 1->0 on this clock edge
// -----------------------------------------------------------------------------
module spi_bs_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_sclk;
    logic             w_tc;

    // Strobes are combinational so the top level acts in the same clock edge
    // that the sclk register toggles on (miso is sampled exactly at the rise).
    assign w_tc   = i_en && (r_div_cnt == DIV_LAST);
    assign o_rise = w_tc && !r_sclk;
    assign o_fall = w_tc &&  r_sclk;
    assign o_sclk = r_sclk;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
        end else if (!i_en) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
        end else if (w_tc) begin
            r_div_cnt <= '0;
            r_sclk    <= ~r_sclk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_bs.sv
// -----------------------------------------------------------------------------
// spi_bs
// Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0). Shifts one byte out on
// mosi while capturing one byte from miso. Back-to-back bytes run with a
// continuous, uniform sclk as long as ib_v is high at the end of each byte.
//
// Build option: define SPI_BS_LSB_FIRST_EN to transmit ib_in[0] first and to
// fill the receive byte so the first received bit lands in rb_o[0]. Default
// (undefined) is MSB first in both directions.
//
// Ports:
//   clock       in   system clock (rising edge)
//   reset       in   asynchronous active-high reset; aborts a transfer
//   ib_v        in   byte valid; sampled in IDLE and at the 8th sclk fall
//   ib_in[7:0]  in   byte to transmit, captured when a byte starts
//   rb_o[7:0]   out  last fully received byte
//   byte_ready  out  one-clock pulse when rb_o updates
//   sclk        out  SPI clock, idles low, period 2*CLK_DIV clocks
//   mosi        out  serial data out, changes at byte start / sclk falls
//   miso        in   serial data in, sampled on sclk rises
// -----------------------------------------------------------------------------
module spi_bs
    import spi_bs_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ib_v,
    input  logic [BYTE_W-1:0] ib_in,
    output logic [BYTE_W-1:0] rb_o,
    output logic              byte_ready,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    state_t               r_state;
    logic [BYTE_W-1:0]    r_tx_sh;
    logic [BYTE_W-1:0]    r_rx_sh;
    logic [BYTE_W-1:0]    r_rb;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic                 r_mosi;
    logic                 r_byte_ready;

    logic                 w_en;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_first_bit;
    logic [BYTE_W-1:0]    w_tx_shifted;
    logic                 w_tx_next_bit;
    logic [BYTE_W-1:0]    w_rx_next;

    assign w_en = (r_state == XFER);

    spi_bs_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clock  (clock),
        .reset  (reset),
        .i_en   (w_en),
        .o_sclk (sclk),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Bit ordering lives only here; the FSM below is order-agnostic.
`ifdef SPI_BS_LSB_FIRST_EN
    assign w_first_bit   = ib_in[0];
    assign w_tx_shifted  = r_tx_sh >> 1;
    assign w_tx_next_bit = r_tx_sh[1];
    assign w_rx_next     = (r_rx_sh >> 1) | {miso, {(BYTE_W-1){1'b0}}};
`else
    assign w_first_bit   = ib_in[BYTE_W-1];
    assign w_tx_shifted  = r_tx_sh << 1;
    assign w_tx_next_bit = r_tx_sh[BYTE_W-2];
    assign w_rx_next     = (r_rx_sh << 1) | BYTE_W'(miso);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_tx_sh      <= '0;
            r_rx_sh      <= '0;
            r_rb         <= '0;
            r_bit_cnt    <= '0;
            r_mosi       <= 1'b0;
            r_byte_ready <= 1'b0;
        end else begin
            // byte_ready is a strobe: low unless the last bit is captured now.
            r_byte_ready <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (ib_v) begin
                        r_tx_sh   <= ib_in;
                        r_mosi    <= w_first_bit;
                        r_bit_cnt <= '0;
                        r_state   <= XFER;
                    end else begin
                        r_mosi    <= 1'b0;
                    end
                end

                XFER: begin
                    if (w_rise) begin
                        r_rx_sh <= w_rx_next;
                        // rb_o takes the full byte in one step, never partially.
                        if (r_bit_cnt == LAST_BIT) begin
                            r_rb         <= w_rx_next;
                            r_byte_ready <= 1'b1;
                        end
                    end

                    if (w_fall) begin
                        if (r_bit_cnt != LAST_BIT) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_tx_sh   <= w_tx_shifted;
                            r_mosi    <= w_tx_next_bit;
                        end else if (ib_v) begin
                            // Reload on the 8th fall: the divider keeps running,
                            // so the next byte follows with no sclk gap.
                            r_tx_sh   <= ib_in;
                            r_mosi    <= w_first_bit;
                            r_bit_cnt <= '0;
                        end else begin
                            r_mosi    <= 1'b0;
                            r_state   <= IDLE;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign rb_o       = r_rb;
    assign byte_ready = r_byte_ready;
    assign mosi       = r_mosi;

endmodule

// File: tb/tb_spi_bs.sv
// -----------------------------------------------------------------------------
// tb_spi_bs
// Self-checking bench for spi_bs. Two instances: CLK_DIV=4 (main) and
// CLK_DIV=1 (fast divider). The bench plays the SPI slave: it presents each
// miso bit after the preceding sclk fall and records mosi at every sclk rise.
// Expected bits, bytes, periods and pulse counts come from the transfer rules
// (bit order, 2*CLK_DIV clock period, one pulse per byte), not from the RTL.
// Honors SPI_BS_LSB_FIRST_EN for the bit-order expectation.
// -----------------------------------------------------------------------------
module tb_spi_bs;

    localparam int DIV_A = 4;
    localparam int DIV_B = 1;
    localparam int TCLK  = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ib_v  = 1'b0;
    logic [7:0] ib_in = 8'h00;
    logic       miso  = 1'b0;
    logic       sel   = 1'b0;   // 0: CLK_DIV=4 instance, 1: CLK_DIV=1 instance

    logic       ib_v_a, ib_v_b;
    logic [7:0] rb_a, rb_b;
    logic       br_a, br_b, sclk_a, sclk_b, mosi_a, mosi_b;

    assign ib_v_a = ib_v & ~sel;
    assign ib_v_b = ib_v &  sel;

    wire       sclk_s = sel ? sclk_b : sclk_a;
    wire       mosi_s = sel ? mosi_b : mosi_a;
    wire [7:0] rb_s   = sel ? rb_b   : rb_a;
    wire       br_s   = sel ? br_b   : br_a;

    spi_bs #(.CLK_DIV(DIV_A)) dut_a (
        .clock(clock), .reset(reset), .ib_v(ib_v_a), .ib_in(ib_in),
        .rb_o(rb_a), .byte_ready(br_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso)
    );

    spi_bs #(.CLK_DIV(DIV_B)) dut_b (
        .clock(clock), .reset(reset), .ib_v(ib_v_b), .ib_in(ib_in),
        .rb_o(rb_b), .byte_ready(br_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso)
    );

    always #(TCLK/2) clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // byte_ready pulse counters and longest observed pulse width
    int br_cnt_a = 0;
    int br_cnt_b = 0;
    int br_run   = 0;
    int br_max   = 0;

    always @(posedge clock) begin
        if (br_a) br_cnt_a++;
        if (br_b) br_cnt_b++;
        if (br_s) begin
            br_run++;
            if (br_run > br_max) br_max = br_run;
        end else begin
            br_run = 0;
        end
    end

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    time        rise_t[$];

    // Bit b (0 = first on the wire) of a byte.
    function automatic logic bit_of(input logic [7:0] x, input int b);
`ifdef SPI_BS_LSB_FIRST_EN
        return x[b];
`else
        return x[7-b];
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Poll once per clock (sclk changes at most once per clock) for an edge.
    task automatic wait_edge(input logic rising, input int budget, output bit ok);
        logic prev;
        prev = sclk_s;
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock); #1;
            if (sclk_s === rising && prev !== rising) begin
                ok = 1'b1;
                break;
            end
            prev = sclk_s;
        end
    endtask

    // Run tx_q/rx_q as one burst. keep_v=1 holds ib_v until the last byte
    // starts; keep_v=0 pulses ib_v for one clock (single byte).
    task automatic run_bytes(input string tag, input bit keep_v);
        int  n;
        int  div;
        int  br_before;
        bit  ok;
        time start_t;
        n   = tx_q.size();
        div = sel ? DIV_B : DIV_A;
        br_before = sel ? br_cnt_b : br_cnt_a;
        rise_t.delete();

        ib_in = tx_q[0];
        miso  = bit_of(rx_q[0], 0);
        ib_v  = 1'b1;
        @(posedge clock); #1;          // controller leaves IDLE on this edge
        start_t = $time;
        if (!keep_v) ib_v = 1'b0;

        for (int j = 0; j < n; j++) begin
            for (int b = 0; b < 8; b++) begin
                if (j != 0 || b != 0) miso = bit_of(rx_q[j], b);
                wait_edge(1'b1, 2*div + 4, ok);
                check({tag, " rise_seen"}, 64'(ok), 64'd1);
                if (!ok) return;
                rise_t.push_back($time);
                check({tag, " mosi_bit"}, 64'(mosi_s), 64'(bit_of(tx_q[j], b)));
                if (b == 0) begin
                    ib_in = 8'($urandom);  // not a sampling point: must be ignored
                    if (j == n-1 && keep_v) ib_v = 1'b0;
                end
                if (b == 4 && j+1 < n) ib_in = tx_q[j+1];
                wait_edge(1'b0, 2*div + 4, ok);
                check({tag, " fall_seen"}, 64'(ok), 64'd1);
                if (!ok) return;
                if (b == 7) begin
                    check({tag, " rb_o"}, 64'(rb_s), 64'(rx_q[j]));
                    if (j+1 < n)
                        check({tag, " next_first_bit"}, 64'(mosi_s), 64'(bit_of(tx_q[j+1], 0)));
                end
            end
        end

        check({tag, " first_rise_delay"}, 64'(rise_t[0] - start_t), 64'(div*TCLK));
        check({tag, " rise_count"}, 64'(rise_t.size()), 64'(8*n));
        for (int k = 1; k < rise_t.size(); k++)
            check({tag, " sclk_period"}, 64'(rise_t[k] - rise_t[k-1]), 64'(2*div*TCLK));

        // Back in IDLE: no further sclk activity, lines low.
        wait_edge(1'b1, 6*div + 4, ok);
        check({tag, " idle_no_rise"}, 64'(ok), 64'd0);
        check({tag, " idle_sclk"}, 64'(sclk_s), 64'd0);
        check({tag, " idle_mosi"}, 64'(mosi_s), 64'd0);
        check({tag, " byte_ready_count"}, 64'((sel ? br_cnt_b : br_cnt_a) - br_before), 64'(n));
    endtask

    initial begin : main
        bit ok;
        int br_snap;

        // ---- reset held, then released ----
        repeat (3) @(posedge clock);
        #1;
        check("rst_held sclk", 64'(sclk_a), 64'd0);
        check("rst_held mosi", 64'(mosi_a), 64'd0);
        check("rst_held rb_o", 64'(rb_a), 64'd0);
        check("rst_held byte_ready", 64'(br_a), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_rel sclk", 64'(sclk_a), 64'd0);
        check("rst_rel mosi", 64'(mosi_a), 64'd0);
        check("rst_rel rb_o", 64'(rb_a), 64'd0);
        check("rst_rel byte_ready", 64'(br_a), 64'd0);
        check("rst_rel b sclk", 64'(sclk_b), 64'd0);

        // ---- reset reasserted mid-byte ----
        ib_in = 8'hFF;
        miso  = 1'b1;
        ib_v  = 1'b1;
        @(posedge clock); #1;
        ib_v  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_edge(1'b1, 2*DIV_A + 4, ok);
            check("midrst rise_seen", 64'(ok), 64'd1);
        end
        br_snap = br_cnt_a;
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        check("midrst sclk_async", 64'(sclk_a), 64'd0);
        check("midrst mosi_async", 64'(mosi_a), 64'd0);
        #10;
        reset = 1'b0;
        repeat (200) @(posedge clock);
        #1;
        check("midrst no_byte_ready", 64'(br_cnt_a - br_snap), 64'd0);
        check("midrst rb_o", 64'(rb_a), 64'd0);
        check("midrst idle_sclk", 64'(sclk_a), 64'd0);

        // ---- single byte 8'hA5, ib_v pulsed one clock ----
        tx_q = '{8'hA5};
        rx_q = '{8'($urandom)};
        run_bytes("tx_a5", 1'b0);

        // ---- random single bytes ----
        for (int r = 0; r < 4; r++) begin
            tx_q = '{8'($urandom)};
            rx_q = '{8'($urandom)};
            run_bytes("rand_single", 1'b0);
        end

        // ---- back-to-back 8'h3C then 8'hC3 ----
        tx_q = '{8'h3C, 8'hC3};
        rx_q = '{8'($urandom), 8'($urandom)};
        run_bytes("b2b", 1'b1);

        // ---- streaming receive j = 0..254, random transmit data ----
        tx_q.delete();
        rx_q.delete();
        for (int j = 0; j < 255; j++) begin
            rx_q.push_back(8'(j));
            tx_q.push_back(8'($urandom));
        end
        run_bytes("stream", 1'b1);

        // ---- CLK_DIV=1 instance ----
        sel = 1'b1;
        br_run = 0;
        tx_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        rx_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        run_bytes("div1_stream", 1'b1);
        tx_q = '{8'($urandom)};
        rx_q = '{8'($urandom)};
        run_bytes("div1_single", 1'b0);
        sel = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("byte_ready width", 64'(br_max), 64'd1);

`ifdef SPI_BS_LSB_FIRST_EN
        // ---- LSB-first: 8'h01 out, 8'h80 in ----
        tx_q = '{8'h01};
        rx_q = '{8'h80};
        run_bytes("lsb_first", 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog: the directed sequence is far shorter than this.
    initial begin
        #(90000 * TCLK);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_bs.md
Name: spi_bs

Overview:
- Byte-oriented SPI master (mode 0: CPOL=0, CPHA=0), MSB first by default.
- Shifts one 8-bit byte out on mosi while capturing one byte from miso, and generates sclk from the system clock.
- Sits between a byte-level host (valid-only input, byte_ready strobe output) and an external SPI slave.
- Supports back-to-back transfers with a continuous sclk while ib_v stays high.

Parameters:
- CLK_DIV, default 4: sclk half-period in system clocks (sclk = clock/(2*CLK_DIV)); legal range >= 1.
- BYTE_W, default 8: transfer width in bits; fixed at 8 for this block.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ib_v  in  1  input byte valid; sampled when idle or at end of a byte.
- ib_in  in  8  byte to transmit; captured in the cycle a byte starts.
- rb_o  out  8  last fully received byte; holds until the next byte completes.
- byte_ready  out  1  one-clock pulse when rb_o is updated.
- sclk  out  1  SPI clock; idles low.
- mosi  out  1  serial data out; changes only on sclk falling edges or at byte start.
- miso  in  1  serial data in; sampled on sclk rising edges.

Behaviour:
- Reset (async, active-high): sclk=0, mosi=0, rb_o=0, byte_ready=0, state=IDLE, counters=0, shift registers=0. Asserting reset mid-transfer aborts the transfer immediately; no byte_ready is issued.
- States: IDLE, XFER.
- IDLE: sclk=0.
  - If ib_v=1: load tx_sh<=ib_in, drive mosi<=ib_in[7], set bit_cnt=0 and div_cnt=0, go to XFER.
  - Otherwise mosi=0.
- XFER, division: div_cnt counts 0..CLK_DIV-1. At terminal count, sclk toggles and div_cnt wraps to 0.
- XFER, rising edge of sclk (0->1 toggle): rx_sh<={rx_sh[6:0], miso}, sampled in that same clock cycle.
  - If bit_cnt==7: rb_o<={rx_sh[6:0], miso} and byte_ready=1 for exactly that one clock.
- XFER, falling edge of sclk (1->0 toggle):
  - If bit_cnt<7: bit_cnt++ and mosi<=next tx bit (MSB first).
  - If bit_cnt==7 and ib_v=1: reload tx_sh<=ib_in, mosi<=ib_in[7], bit_cnt=0, stay in XFER. The sclk period stays uniform, with no gap between bytes.
  - If bit_cnt==7 and ib_v=0: go to IDLE with sclk=0 and mosi=0.
- Timing:
  - First sclk rising edge occurs CLK_DIV clocks after leaving IDLE, so mosi has a setup time of one half-period.
  - Byte latency from start to byte_ready is 15*CLK_DIV clocks (approx).
  - rb_o is valid before the 8th sclk falling edge.
- ib_v is sampled only in IDLE and at the 8th falling edge. ib_in changes at other times have no effect.
- byte_ready never asserts in IDLE. rb_o is never partially updated.

Optional Feature:
- Macro SPI_BS_LSB_FIRST_EN.
- Defined: mosi transmits ib_in[0] first, and the receive shift fills so that the first received bit lands in rb_o[0].
- Undefined (default): MSB first on both mosi and miso, as described above.

Decomposition:
- Package spi_bs_pkg holds:
  - state enum (IDLE, XFER)
  - BYTE_W = 8
  - bit-counter width = 3
- Natural sub-module spi_bs_clkgen: div_cnt, the sclk register, and one-cycle sclk_rise/sclk_fall strobes.
- The top level holds the FSM, shift registers, rb_o, byte_ready and mosi.

Test Plan:
- Reset: hold reset high, then release.
  - Required: sclk=0, mosi=0, rb_o=0, byte_ready=0.
  - Reassert reset mid-byte: sclk drops to 0 asynchronously and no byte_ready follows.
- Streaming receive: ib_v=1 continuously; drive miso with byte j MSB first, updating after each sclk falling edge, for j=0..254.
  - Required: rb_o==j after every 8th sclk falling edge.
  - Required: exactly one byte_ready pulse per byte.
- Transmit: ib_in=8'hA5 with ib_v pulsed for 1 clock while IDLE.
  - Required: mosi sampled at the sclk rising edges reads 1,0,1,0,0,1,0,1.
  - Required: then 8 sclk pulses only, then IDLE with sclk=0.
- Back-to-back: ib_v=1 with ib_in=8'h3C, then 8'hC3.
  - Required: 16 uniform sclk periods with no gap.
  - Required: second byte's MSB appears on mosi at the 8th falling edge.
- Divider: CLK_DIV=1 and CLK_DIV=4.
  - Required: sclk period of 2 and 8 clocks respectively.
  - Required: byte_ready is one clock wide.
- Optional: with SPI_BS_LSB_FIRST_EN defined, ib_in=8'h01 -> mosi=1 on the first rising edge; miso LSB-first 8'h80 -> rb_o=8'h80.
